// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a full-width immediate into a
// 32-bit word through a two-stage valid/ready pipeline, flagging out-of-range immediates.
module instr_encoder #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             immSrc,
    input  logic                   jumpSrc,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [2:0]             funct3,
    input  logic [DATA_WIDTH-1:0]  imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_err,
    output logic [7:0]             err_cnt,
    input  logic                   addr_load,
    input  logic [ADDR_WIDTH-1:0]  addr_value
);
    logic                   r_s1_valid, r_s2_valid;
    logic [1:0]             r_s1_immsrc;
    logic                   r_s1_jump;
    logic [6:0]             r_s1_opcode;
    logic [4:0]             r_s1_rd, r_s1_rs1, r_s1_rs2;
    logic [2:0]             r_s1_funct3;
    logic [DATA_WIDTH-1:0]  r_s1_imm;
    logic                   r_s1_err;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_err;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [7:0]             r_err_cnt;
    logic                   w_adv1, w_in_ready, w_out_xfer, w_range_err;
    logic [INSTR_WIDTH-1:0] w_word;

    // in_ready depends only on pipeline state and out_ready, never on in_valid
    assign w_adv1     = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_adv1;
    assign w_out_xfer = r_s2_valid && out_ready;

    // An immediate is legal when the bits above the format's field are a pure sign extension
    always_comb begin
        w_range_err = 1'b0;
        unique case (immSrc)
            2'b00, 2'b01: w_range_err = !(&imm[31:11] || ~|imm[31:11]);
            2'b10:        w_range_err = imm[0] || !(&imm[31:12] || ~|imm[31:12]);
            default:      w_range_err = jumpSrc ? (imm[0] || !(&imm[31:20] || ~|imm[31:20]))
                                                : (|imm[11:0]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_immsrc <= '0;
            r_s1_jump   <= 1'b0;
            r_s1_opcode <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_funct3 <= '0;
            r_s1_imm    <= '0;
            r_s1_err    <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_immsrc <= immSrc;
                r_s1_jump   <= jumpSrc;
                r_s1_opcode <= opcode;
                r_s1_rd     <= rd;
                r_s1_rs1    <= rs1;
                r_s1_rs2    <= rs2;
                r_s1_funct3 <= funct3;
                r_s1_imm    <= imm;
                r_s1_err    <= w_range_err;
            end
        end
    end

    // Out-of-range immediates are simply truncated into the field positions
    always_comb begin
        w_word = '0;
        unique case (r_s1_immsrc)
            2'b00: w_word[31:0] = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
            2'b01: w_word[31:0] = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                   r_s1_imm[4:0], r_s1_opcode};
            2'b10: w_word[31:0] = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                   r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
            default: begin
                if (r_s1_jump)
                    w_word[31:0] = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                                    r_s1_rd, r_s1_opcode};
                else
                    w_word[31:0] = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_instr    <= '0;
            r_err      <= 1'b0;
        end else if (w_adv1) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_instr <= w_word;
                r_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= BASE_ADDR;
            r_err_cnt <= '0;
        end else begin
            if (addr_load)
                r_addr <= addr_value;
            else if (w_out_xfer)
                r_addr <= r_addr + ADDR_WIDTH'(4);
            if (w_out_xfer && r_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_s2_valid;
    assign instruction = r_instr;
    assign out_err     = r_err;
    assign out_addr    = r_addr;
    assign err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at accept, checked at output,
// with an independent encoder/range model and an immediate round-trip decode.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [1:0]  immSrc = '0;
    logic        jumpSrc = 1'b0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] instruction;
    logic [11:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic        addr_load = 1'b0;
    logic [11:0] addr_value = '0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0, n_bad = 0;
    logic [11:0] m_addr = '0;
    int          m_errs = 0;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .immSrc(immSrc), .jumpSrc(jumpSrc), .opcode(opcode), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .instruction(instruction), .out_addr(out_addr),
        .out_err(out_err), .err_cnt(err_cnt), .addr_load(addr_load),
        .addr_value(addr_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] is, input logic js, input logic [6:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [31:0] im);
        case (is)
            2'd0:    return {im[11:0], s1, f3, d, op};
            2'd1:    return {im[11:5], s2, s1, f3, im[4:0], op};
            2'd2:    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            default: return js ? {im[20], im[10:1], im[11], im[19:12], d, op}
                               : {im[31:12], d, op};
        endcase
    endfunction

    function automatic logic eerr(input logic [1:0] is, input logic js, input logic [31:0] im);
        int signed v;
        v = $signed(im);
        case (is)
            2'd0, 2'd1: return (v < -2048) || (v > 2047);
            2'd2:       return im[0] || (v < -4096) || (v > 4095);
            default:    return js ? (im[0] || (v < -1048576) || (v > 1048575))
                                  : (im[11:0] != 12'd0);
        endcase
    endfunction

    // Immediate extender, used to confirm the round trip on legal words
    function automatic logic [31:0] dec(input logic [31:0] w, input logic [2:0] fmt);
        case (fmt[2:1])
            2'd0:    return {{20{w[31]}}, w[31:20]};
            2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return fmt[0] ? {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}
                                   : {w[31:12], 12'd0};
        endcase
    endfunction

    task automatic send(input logic [1:0] is, input logic js, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [31:0] im,
                        input logic [31:0] e_instr, input logic e_err);
        exp_t e;
        bit   ok = 0;
        in_valid = 1'b1; immSrc = is; jumpSrc = js; opcode = op;
        rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.instr = e_instr; e.err = e_err; e.fmt = {is, js}; e.imm = im;
            sb.push_back(e);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [1:0] is, input logic js, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [2:0] f3, input logic [31:0] im);
        send(is, js, op, d, s1, s2, f3, im, enc(is, js, op, d, s1, s2, f3, im), eerr(is, js, im));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", sb.size(), 32'd0);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_addr = '0;
            m_errs = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", instruction, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instr", instruction, e.instr);
                    chk("out_err", {31'd0, out_err}, {31'd0, e.err});
                    chk("out_addr", {20'd0, out_addr}, {20'd0, m_addr});
                    chk("err_cnt", {24'd0, err_cnt}, m_errs);
                    if (!e.err) chk("roundtrip", dec(instruction, e.fmt), e.imm);
                    if (e.err && m_errs < 255) m_errs++;
                end
                m_addr = m_addr + 12'd4;
            end
            if (addr_load) m_addr = addr_value;
        end
    end

    initial begin
        logic [31:0] r, im;
        logic [1:0]  is;
        logic        js;
        bit          seen;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_addr", {20'd0, out_addr}, 32'd0);
        @(posedge clk); #1;

        // addi x1, x0, 5 with latency check
        send(2'd0, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
        chk("lat_c1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_c2", {31'd0, out_valid}, 32'd1);
        drain();

        // Back-to-back S, B, J, U
        send(2'd1, 1'b0, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020A423, 1'b0);
        send(2'd2, 1'b0, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        send(2'd3, 1'b1, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 32'h001000EF, 1'b0);
        send(2'd3, 1'b0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);
        drain();

        // Range errors
        send(2'd0, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h80000093, 1'b1);
        send(2'd2, 1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3,
             enc(2'd2, 1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3), 1'b1);
        drain();
        chk("err_cnt_2", {24'd0, err_cnt}, 32'd2);

        // Backpressure: two words buffered, third stalls
        out_ready = 1'b0;
        fork
            begin
                send(2'd0, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
                send_m(2'd1, 1'b0, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFFFFF0);
                send_m(2'd0, 1'b0, 7'h13, 5'd7, 5'd6, 5'd0, 3'd4, 32'h7FF);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_instr", instruction, 32'h00500093);
                repeat (2) @(negedge clk);
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_instr", instruction, 32'h00500093);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Address load wins over increment, then wraps
        fork
            begin
                send_m(2'd0, 1'b0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1);
                send_m(2'd0, 1'b0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd2);
                send_m(2'd0, 1'b0, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd3);
            end
            begin
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(posedge clk); #1;
                    seen = out_valid;
                end
                chk("load_wait", {31'd0, seen}, 32'd1);
                addr_load = 1'b1; addr_value = 12'hFFC;
                @(posedge clk); #1 addr_load = 1'b0;
                chk("addr_loaded", {20'd0, out_addr}, 32'hFFC);
            end
        join
        drain();

        // Random mix of formats, legal and illegal immediates
        for (int n = 0; n < 300; n++) begin
            r  = $urandom;
            is = 2'($urandom_range(0, 3));
            js = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                case (is)
                    2'd0, 2'd1: im = {{20{r[11]}}, r[11:0]};
                    2'd2:       im = {{19{r[12]}}, r[12:1], 1'b0};
                    default:    im = js ? {{11{r[20]}}, r[20:1], 1'b0} : {r[31:12], 12'd0};
                endcase
            end else begin
                im = r;
            end
            send_m(is, js, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), im);
        end
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send_m(2'd0, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd9);
        send_m(2'd0, 1'b0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd4096);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("mid_rst_addr", {20'd0, out_addr}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(2'd3, 1'b0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);
        chk("post_rst_c1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_c2", {31'd0, out_valid}, 32'd1);
        chk("post_rst_instr", instruction, 32'h123452B7);
        drain();

        // Saturation of the error counter
        for (int n = 0; n < 260; n++)
            send(2'd0, 1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h80000093, 1'b1);
        drain();
        chk("err_sat", {24'd0, err_cnt}, 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
